// File: rtl/tcb_fault_pkg.sv
// ============================================================================
// Module : tcb_fault_pkg
// Brief  : Shared constants and helper functions for the codeword fault monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tcb_fault_pkg;

  localparam logic EVT_SA0  = 1'b0;
  localparam logic EVT_SA1  = 1'b1;
  localparam int   CNT_BITS = 4;

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v,
                                                  input logic [CNT_BITS-1:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fault_bit_tracker.sv
// ============================================================================
// Module : fault_bit_tracker
// Brief  : Per-bit stuck-at evidence counters, sticky maps and declare pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fault_bit_tracker
  import tcb_fault_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_orig,
  input  logic i_inf,
  output logic o_sa0_map,
  output logic o_sa1_map,
  output logic o_decl0,
  output logic o_decl1
);

  localparam logic [CNT_BITS-1:0] c_thresh = CNT_BITS'(THRESH);
  localparam logic [CNT_BITS-1:0] c_pre    = CNT_BITS'(THRESH - 1);

  logic [CNT_BITS-1:0] r_sa0_cnt;
  logic [CNT_BITS-1:0] r_sa1_cnt;
  logic                r_sa0_map;
  logic                r_sa1_map;
  logic                w_ev0;
  logic                w_ev1;

  assign w_ev0 = i_orig & ~i_inf;
  assign w_ev1 = ~i_orig & i_inf;

  // A bit already in the map never re-declares, even if its counter climbs again.
  assign o_decl0   = i_en && w_ev0 && (r_sa0_cnt == c_pre) && !r_sa0_map;
  assign o_decl1   = i_en && w_ev1 && (r_sa1_cnt == c_pre) && !r_sa1_map;
  assign o_sa0_map = r_sa0_map;
  assign o_sa1_map = r_sa1_map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa0_cnt <= '0;
      r_sa1_cnt <= '0;
      r_sa0_map <= 1'b0;
      r_sa1_map <= 1'b0;
    end else if (i_clear) begin
      r_sa0_cnt <= '0;
      r_sa1_cnt <= '0;
      r_sa0_map <= 1'b0;
      r_sa1_map <= 1'b0;
    end else if (i_en) begin
      if (i_orig) begin
        r_sa0_cnt <= i_inf ? '0 : sat_inc(r_sa0_cnt, c_thresh);
      end else begin
        r_sa1_cnt <= i_inf ? sat_inc(r_sa1_cnt, c_thresh) : '0;
      end
      r_sa0_map <= r_sa0_map | o_decl0;
      r_sa1_map <= r_sa1_map | o_decl1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/codeword_fault_monitor.sv
// ============================================================================
// Module : codeword_fault_monitor
// Brief  : Compares clean vs infected codeword lines, declares stuck bits and
//          reports each new declaration as a valid/ready event.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module codeword_fault_monitor
  import tcb_fault_pkg::*;
#(
  parameter int W      = 20,
  parameter int THRESH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_enable,
  input  logic                  valid,
  input  logic                  clear,
  input  logic [W-1:0]          original_codeword_line,
  input  logic [W-1:0]          infected_codeword_line,
  output logic [W-1:0]          stuck_at0_map,
  output logic [W-1:0]          stuck_at1_map,
  output logic [CNT_W-1:0]      mismatch_count,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [idx_w(W)-1:0]   evt_bit,
  output logic                  evt_type
);

  localparam int IW  = idx_w(W);
  localparam int PCW = $clog2(W + 1);

  logic [W-1:0]     r_orig;
  logic [W-1:0]     r_inf;
  logic             r_s1_valid;
  logic [W-1:0]     w_decl0;
  logic [W-1:0]     w_decl1;
  logic [W-1:0]     w_diff;
  logic [PCW-1:0]   w_pc;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_p0;
  logic [W-1:0]     r_p1;
  logic [W-1:0]     w_p0_nxt;
  logic [W-1:0]     w_p1_nxt;
  logic             w_ack;
  logic             w_sel_any;
  logic [IW-1:0]    w_sel_bit;
  logic             w_sel_type;
  logic             r_evt_valid;
  logic [IW-1:0]    r_evt_bit;
  logic             r_evt_type;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_orig     <= '0;
      r_inf      <= '0;
      r_s1_valid <= 1'b0;
    end else if (clear) begin
      r_orig     <= '0;
      r_inf      <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= clk_enable && valid;
      if (clk_enable && valid) begin
        r_orig <= original_codeword_line;
        r_inf  <= infected_codeword_line;
      end
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_bit
    fault_bit_tracker #(.THRESH(THRESH)) u_trk (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (clear),
      .i_en      (r_s1_valid),
      .i_orig    (r_orig[g]),
      .i_inf     (r_inf[g]),
      .o_sa0_map (stuck_at0_map[g]),
      .o_sa1_map (stuck_at1_map[g]),
      .o_decl0   (w_decl0[g]),
      .o_decl1   (w_decl1[g])
    );
  end

  assign w_diff = (r_orig ^ r_inf) & {W{r_s1_valid}};

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < W; i++) begin
      w_pc = w_pc + PCW'(w_diff[i]);
    end
  end

  assign w_sum = {1'b0, r_cnt} + (CNT_W + 1)'(w_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (r_s1_valid) begin
      r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
  end

  assign mismatch_count = r_cnt;
  assign w_ack          = r_evt_valid && evt_ready;

  always_comb begin
    w_p0_nxt = r_p0;
    w_p1_nxt = r_p1;
    if (w_ack) begin
      if (r_evt_type == EVT_SA0) w_p0_nxt[r_evt_bit] = 1'b0;
      else                       w_p1_nxt[r_evt_bit] = 1'b0;
    end
    w_p0_nxt = w_p0_nxt | w_decl0;
    w_p1_nxt = w_p1_nxt | w_decl1;
  end

  // Descending scan so the lowest index wins; type 0 beats type 1 at one index.
  always_comb begin
    w_sel_any  = |{w_p0_nxt, w_p1_nxt};
    w_sel_bit  = '0;
    w_sel_type = EVT_SA0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_p0_nxt[i] || w_p1_nxt[i]) begin
        w_sel_bit  = IW'(i);
        w_sel_type = w_p0_nxt[i] ? EVT_SA0 : EVT_SA1;
      end
    end
  end

  // The presented event is frozen until accepted, so new lower-index
  // declarations wait for the current handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0        <= '0;
      r_p1        <= '0;
      r_evt_valid <= 1'b0;
      r_evt_bit   <= '0;
      r_evt_type  <= 1'b0;
    end else if (clear) begin
      r_p0        <= '0;
      r_p1        <= '0;
      r_evt_valid <= 1'b0;
      r_evt_bit   <= '0;
      r_evt_type  <= 1'b0;
    end else begin
      r_p0 <= w_p0_nxt;
      r_p1 <= w_p1_nxt;
      if (!(r_evt_valid && !evt_ready)) begin
        r_evt_valid <= w_sel_any;
        r_evt_bit   <= w_sel_bit;
        r_evt_type  <= w_sel_type;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_bit   = r_evt_bit;
  assign evt_type  = r_evt_type;

endmodule

`default_nettype wire

// File: tb/tb_codeword_fault_monitor.sv
// ============================================================================
// Module : tb_codeword_fault_monitor
// Brief  : Directed self-checking bench for codeword_fault_monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_codeword_fault_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_enable = 1'b0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic        evt_ready = 1'b0;
  logic [19:0] orig = '0;
  logic [19:0] inf = '0;

  logic [19:0] sa0_map, sa1_map, sa0_map8, sa1_map8;
  logic [31:0] mcount;
  logic [7:0]  mcount8;
  logic        evt_valid, evt_type, evt_valid8, evt_type8;
  logic [4:0]  evt_bit, evt_bit8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  codeword_fault_monitor #(.W(20), .THRESH(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .valid(valid), .clear(clear),
    .original_codeword_line(orig), .infected_codeword_line(inf),
    .stuck_at0_map(sa0_map), .stuck_at1_map(sa1_map), .mismatch_count(mcount),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_bit(evt_bit), .evt_type(evt_type)
  );

  codeword_fault_monitor #(.W(20), .THRESH(4), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .valid(valid), .clear(clear),
    .original_codeword_line(orig), .infected_codeword_line(inf),
    .stuck_at0_map(sa0_map8), .stuck_at1_map(sa1_map8), .mismatch_count(mcount8),
    .evt_valid(evt_valid8), .evt_ready(evt_ready), .evt_bit(evt_bit8), .evt_type(evt_type8)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [19:0] o, input logic [19:0] x);
    orig = o; inf = x; valid = 1'b1; clk_enable = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic idle();
    valid = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_sa0", sa0_map, 0);
    chk("reset_sa1", sa1_map, 0);
    chk("reset_cnt", mcount, 0);
    chk("reset_evt", evt_valid, 0);
    rst_n = 1'b1;
    step();

    // 1: bit 3 stuck-at-0 after four evidence samples
    for (int i = 0; i < 4; i++) sample(20'hFFFFF, 20'hFFFF7);
    chk("t1_not_yet", sa0_map, 0);
    chk("t1_cnt3", mcount, 3);
    idle();
    chk("t1_map", sa0_map, 20'h00008);
    chk("t1_cnt", mcount, 4);
    chk("t1_evt_v", evt_valid, 1);
    chk("t1_evt_bit", evt_bit, 3);
    chk("t1_evt_type", evt_type, 0);
    evt_ready = 1'b1;
    idle();
    evt_ready = 1'b0;
    chk("t1_evt_done", evt_valid, 0);
    do_clear();

    // 2: a clean sample resets the evidence count
    sample(20'hFFFFF, 20'hFFFF7);
    sample(20'hFFFFF, 20'hFFFF7);
    sample(20'hFFFFF, 20'hFFFFF);
    for (int i = 0; i < 3; i++) sample(20'hFFFFF, 20'hFFFF7);
    idle();
    chk("t2_not_yet", sa0_map, 0);
    sample(20'hFFFFF, 20'hFFFF7);
    idle();
    chk("t2_map", sa0_map, 20'h00008);
    chk("t2_cnt", mcount, 6);
    do_clear();

    // 3: two simultaneous stuck-at-1 declarations, back-pressured
    for (int i = 0; i < 4; i++) sample(20'h00000, 20'h00084);
    idle();
    chk("t3_map1", sa1_map, 20'h00084);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_v", evt_valid, 1);
      chk("t3_hold_bit", evt_bit, 2);
      chk("t3_hold_type", evt_type, 1);
      idle();
    end
    evt_ready = 1'b1;
    idle();
    chk("t3_second_v", evt_valid, 1);
    chk("t3_second_bit", evt_bit, 7);
    idle();
    chk("t3_drained", evt_valid, 0);
    evt_ready = 1'b0;
    do_clear();

    // 4: disabled cycles carry reset-worthy data that must be ignored
    for (int k = 0; k < 4; k++) begin
      orig = 20'hFFFFF; inf = 20'hFFFDF; valid = 1'b1; clk_enable = 1'b1;
      step();
      inf = 20'hFFFFF; clk_enable = 1'b0;
      step();
      if (k == 2) chk("t4_not_yet", sa0_map, 0);
    end
    valid = 1'b0;
    chk("t4_map", sa0_map, 20'h00020);
    chk("t4_cnt", mcount, 4);
    do_clear();

    // 5: saturation of the narrow counter
    for (int i = 0; i < 12; i++) sample(20'h00000, 20'hFFFFF);
    idle();
    chk("t5_cnt8_240", mcount8, 8'hF0);
    chk("t5_cnt32_240", mcount, 240);
    sample(20'h00000, 20'hFFFFF);
    idle();
    chk("t5_cnt8_sat", mcount8, 8'hFF);
    sample(20'h00000, 20'hFFFFF);
    idle();
    chk("t5_cnt8_hold", mcount8, 8'hFF);
    chk("t5_cnt32", mcount, 280);

    // 6: clear with pending events, then async reset mid-transfer
    chk("t6_pend_v", evt_valid, 1);
    chk("t6_pend_bit", evt_bit, 0);
    chk("t6_pend_type", evt_type, 1);
    do_clear();
    chk("t6_clr_v", evt_valid, 0);
    chk("t6_clr_map", sa1_map, 0);
    chk("t6_clr_cnt", mcount, 0);
    for (int i = 0; i < 4; i++) sample(20'hFFFFF, 20'hFFFF7);
    idle();
    chk("t6_re_v", evt_valid, 1);
    evt_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_v", evt_valid, 0);
    chk("t6_rst_map", sa0_map, 0);
    chk("t6_rst_cnt", mcount, 0);
    step();
    rst_n = 1'b1;
    evt_ready = 1'b0;
    idle();
    chk("t6_post_v", evt_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
